// File: rtl/ntt_address_controller_pkg.sv
// ntt_pkg: shared definitions for the NTT address controller.
// Contents:
//   state_t      - controller FSM states
//   addr_pair_t  - operand address pair as 32-bit fields; callers truncate
//   ntt_pair()   - butterfly address pair for (stage, j) in an in-place
//                  radix-2 NTT over 2^nstages coefficients
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } addr_pair_t;

    // Butterfly j of a stage splits into group g and offset o within that
    // group.
    // - Each group spans 2*d coefficients, where d = 1 << stage.
    // - The upper operand sits at the group base plus o.
    // - The lower operand sits d above the upper operand.
    function automatic addr_pair_t ntt_pair(
        input logic [31:0] stage,
        input logic [31:0] j,
        input int unsigned nstages
    );
        logic [31:0] d;
        logic [31:0] g;
        logic [31:0] o;
        logic [31:0] a;
        logic [31:0] mask;
        addr_pair_t  pair;
        d       = 32'd1 << stage;
        g       = j >> stage;
        o       = j & (d - 32'd1);
        a       = (g << (stage + 32'd1)) | o;
        mask    = (32'd1 << nstages) - 32'd1;
        pair.a  = a & mask;
        pair.b  = (a + d) & mask;
        return pair;
    endfunction

endpackage

// File: rtl/ntt_address_controller_if.sv
// ntt_address_controller_if: bus between the NTT address controller and the
// memory, twiddle generator and butterfly datapath around it.
// Signals:
//   start                   - request to run a full NTT (into the controller)
//   busy, finished          - operation status
//   done                    - butterfly-issue strobe for the twiddle generator
//   stage                   - stage currently being read
//   readEn, readAddrA/B     - read address pair
//   writeEn, writeAddrA/B   - write-back address pair
// Modports:
//   master - the controller
//   slave  - the consumer of the address streams
interface ntt_address_controller_if #(
    parameter int numberStages = 8
);
    localparam int STAGE_W = (numberStages > 1) ? $clog2(numberStages) : 1;

    logic                    start;
    logic                    busy;
    logic                    done;
    logic [STAGE_W-1:0]      stage;
    logic                    readEn;
    logic [numberStages-1:0] readAddrA;
    logic [numberStages-1:0] readAddrB;
    logic                    writeEn;
    logic [numberStages-1:0] writeAddrA;
    logic [numberStages-1:0] writeAddrB;
    logic                    finished;

    modport master (
        input  start,
        output busy, done, stage, readEn, readAddrA, readAddrB,
               writeEn, writeAddrA, writeAddrB, finished
    );

    modport slave (
        output start,
        input  busy, done, stage, readEn, readAddrA, readAddrB,
               writeEn, writeAddrA, writeAddrB, finished
    );

endinterface

// File: rtl/ntt_address_controller_delay_line.sv
// ntt_delay_line: shift register, WIDTH bits wide and DEPTH stages deep.
// It has a synchronous clear.
// Ports:
//   clk   - clock
//   clear - synchronous clear of every stage
//   din   - value entering the line
//   dout  - value that entered DEPTH cycles earlier
module ntt_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/ntt_address_controller.sv
// ntt_address_controller: sequences every stage of an in-place radix-2 NTT
// over 2^numberStages coefficients.
//
// Operation:
//   - Issues one butterfly read pair per cycle.
//   - Pulses done once for each butterfly issued.
//   - Replays the read pair as a write pair bfLatency cycles later.
//   - Between stages, pauses reads for bfLatency cycles. This lets the last
//     write of a stage land before the next stage reads.
//
// Ports:
//   clk - clock
//   rst - synchronous active-high reset; aborts any operation in flight
//   bus - ntt_address_controller_if master modport
//         (start in; status and address streams out)
module ntt_address_controller
    import ntt_pkg::*;
#(
    parameter int numberStages = 8,
    parameter int bfLatency    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    ntt_address_controller_if.master bus
);

    localparam int STAGE_W = (numberStages > 1) ? $clog2(numberStages) : 1;
    localparam int DL_W    = 1 + 2 * numberStages;

    localparam logic [numberStages-1:0] J_LAST     = numberStages'((1 << (numberStages - 1)) - 1);
    localparam logic [STAGE_W-1:0]      STAGE_LAST = STAGE_W'(numberStages - 1);
    localparam logic [3:0]              DRAIN_LAST = 4'(bfLatency - 1);

    state_t                  state;
    state_t                  next_state;
    logic [numberStages-1:0] j;
    logic [numberStages-1:0] next_j;
    logic [STAGE_W-1:0]      stage_cnt;
    logic [STAGE_W-1:0]      next_stage;
    logic [3:0]              drain_cnt;
    logic [3:0]              next_drain;

    addr_pair_t              pair;
    logic                    unused_pair_bits;

    logic                    read_en_q;
    logic [numberStages-1:0] addr_a_q;
    logic [numberStages-1:0] addr_b_q;
    logic                    busy_q;
    logic                    finished_q;
    logic [STAGE_W-1:0]      stage_q;

    logic [DL_W-1:0]         dl_out;

    // State register and the butterfly, stage and drain counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            stage_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= next_state;
            j         <= next_j;
            stage_cnt <= next_stage;
            drain_cnt <= next_drain;
        end
    end

    // Next-state logic.
    // Outputs are registered from the next-state values, so every output
    // describes the state the FSM is entering.
    always_comb begin
        next_state = state;
        next_j     = j;
        next_stage = stage_cnt;
        next_drain = drain_cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = RUN;
                    next_j     = '0;
                    next_stage = '0;
                end
            end
            RUN: begin
                if (j == J_LAST) begin
                    next_state = DRAIN;
                    next_j     = '0;
                    next_drain = '0;
                end else begin
                    next_j = j + numberStages'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    if (stage_cnt == STAGE_LAST) begin
                        next_state = FINISH;
                    end else begin
                        next_state = RUN;
                        next_stage = stage_cnt + STAGE_W'(1);
                    end
                end else begin
                    next_drain = drain_cnt + 4'd1;
                end
            end
            FINISH: begin
                next_state = IDLE;
                next_stage = '0;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign pair             = ntt_pair(32'(next_stage), 32'(next_j), numberStages);
    assign unused_pair_bits = ^{pair.a[31:numberStages], pair.b[31:numberStages]};

    // Registered read side and status outputs.
    // Addresses are held at zero when no read is issued. Idle entries in the
    // write stream therefore carry zero addresses as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_en_q  <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            stage_q    <= '0;
        end else begin
            read_en_q  <= (next_state == RUN);
            addr_a_q   <= (next_state == RUN) ? pair.a[numberStages-1:0] : '0;
            addr_b_q   <= (next_state == RUN) ? pair.b[numberStages-1:0] : '0;
            busy_q     <= (next_state != IDLE);
            finished_q <= (next_state == FINISH);
            stage_q    <= next_stage;
        end
    end

    // Write-back stream: the registered read stream delayed by the butterfly
    // latency.
    ntt_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (bfLatency)
    ) u_delay (
        .clk   (clk),
        .clear (rst),
        .din   ({read_en_q, addr_a_q, addr_b_q}),
        .dout  (dl_out)
    );

    assign bus.readEn     = read_en_q;
    assign bus.done       = read_en_q;
    assign bus.readAddrA  = addr_a_q;
    assign bus.readAddrB  = addr_b_q;
    assign bus.busy       = busy_q;
    assign bus.finished   = finished_q;
    assign bus.stage      = stage_q;
    assign bus.writeEn    = dl_out[DL_W-1];
    assign bus.writeAddrA = dl_out[2*numberStages-1:numberStages];
    assign bus.writeAddrB = dl_out[numberStages-1:0];

endmodule
